ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, for example 0xED set-LEDs, 0xFF reset and 0xF4 enable. It drives the shared PS/2 clock and data lines through open-drain enables, generates the request-to-send sequence, shifts the frame out on device clock edges, and checks the device's line-level acknowledge. The device's response byte (0xFA etc.) arrives through the existing PS/2 receiver on the same lines.

---
 rtl/ps2_host_tx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter.
//
// Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to a
// PS/2 device. The host inhibits the bus, issues request-to-send, shifts out
// {stop, odd parity, data[7:0], start} on device-generated clock falling edges
// and checks the device's line-level acknowledge. The device's response byte
// arrives through the separate PS/2 receiver sharing the same lines.
//
// Ports:
//   clock         system clock
//   reset         asynchronous active-low reset
//   ps2_clock     raw PS/2 clock line (asynchronous)
//   data          raw PS/2 data line (asynchronous)
//   ps2_clock_oe  1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe   1 = pull PS/2 data low, 0 = release
//   tx_data       command byte, taken when tx_valid & tx_ready
//   tx_valid      transmit request
//   tx_ready      idle, can accept a byte
//   busy          transfer in progress
//   done          one-cycle pulse: frame acknowledged by the device
//   error         one-cycle pulse: missing ack or timeout
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 1200,   // min 2
  parameter int unsigned TIMEOUT_CYCLES = 240000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       data,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  logic [2:0]       state_q,    state_d;
  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       dat_sync_q, dat_sync_d;
  logic [8:0]       frame_q,    frame_d;
  logic [3:0]       edge_cnt_q, edge_cnt_d;
  logic [INH_W-1:0] inh_cnt_q,  inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q,   to_cnt_d;
  logic             clk_oe_q,   clk_oe_d;
  logic             data_oe_q,  data_oe_d;
  logic             done_q,     done_d;
  logic             error_q,    error_d;

  logic clk_fall;
  logic clk_s;
  logic dat_s;
  logic timed_out;

  // Line synchronisers; the clock gets a third stage so edge detection
  // compares two already-settled samples.
  assign clk_sync_d = {clk_sync_q[1:0], ps2_clock};
  assign dat_sync_d = {dat_sync_q[0], data};

  assign clk_fall  = (clk_sync_q[2:1] == 2'b10);
  assign clk_s     = clk_sync_q[1];
  assign dat_s     = dat_sync_q[1];
  assign timed_out = (to_cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    edge_cnt_d = edge_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          // Odd parity: parity bit makes the total count of ones odd.
          frame_d   = {~^tx_data, tx_data};
          clk_oe_d  = 1'b1;
          inh_cnt_d = INH_LOAD;
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (inh_cnt_q == '0) begin
          data_oe_d = 1'b1;          // start bit
          state_d   = ST_RTS;
        end else begin
          inh_cnt_d = inh_cnt_q - 1'b1;
        end
      end

      ST_RTS: begin
        clk_oe_d   = 1'b0;           // hand the clock to the device
        edge_cnt_d = '0;
        to_cnt_d   = '0;
        state_d    = ST_SHIFT;
      end

      ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
        if (timed_out) begin
          error_d   = 1'b1;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          case (state_q)
            ST_SHIFT: begin
              if (clk_fall) begin
                if (edge_cnt_q == 4'd9) begin
                  // Tenth edge: release data so the line floats high as stop.
                  data_oe_d = 1'b0;
                  state_d   = ST_ACK;
                end else begin
                  // Edges 1..9: data bits LSB first, then parity.
                  data_oe_d  = ~frame_q[0];
                  frame_d    = {1'b0, frame_q[8:1]};
                  edge_cnt_d = edge_cnt_q + 1'b1;
                end
              end
            end
            ST_ACK: begin
              if (clk_fall) begin
                if (!dat_s) begin
                  state_d = ST_WAIT_IDLE;
                end else begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
                end
              end
            end
            default: begin
              // Device finishes the ack by releasing both lines.
              if (clk_s && dat_s) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
          endcase
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
      frame_q    <= '0;
      edge_cnt_q <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      frame_q    <= frame_d;
      edge_cnt_q <= edge_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign ps2_clock_oe = clk_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign tx_ready     = (state_q == ST_IDLE);
  assign busy         = ~tx_ready;
  assign done         = done_q;
  assign error        = error_q;

endmodule
